// File: rtl/axi_mem_slave_pkg.sv
// Shared AXI encodings, field widths and FSM state types for the AXI4 responder memory model.
package axi_mem_slave_pkg;

  localparam int unsigned AXI_LEN_WIDTH   = 8;
  localparam int unsigned AXI_SIZE_WIDTH  = 3;
  localparam int unsigned AXI_BURST_WIDTH = 2;
  localparam int unsigned AXI_RESP_WIDTH  = 2;

  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Response codes are ordered by severity, so the worst is the numeric max.
  function automatic logic [AXI_RESP_WIDTH-1:0] worst_resp(
    input logic [AXI_RESP_WIDTH-1:0] a,
    input logic [AXI_RESP_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-organised backing store: one byte-strobed write port and one combinational read port.
module axi_mem_array
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned DW    = 64,
  parameter int unsigned IDXW  = $clog2(WORDS)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_widx,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic [IDXW-1:0] i_ridx,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < DW/8; b++) begin
        if (i_wstrb[b]) r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory model: independent read and write burst engines over a byte-strobed word array.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       aw_valid,
  output logic                       aw_ready,
  input  logic [ADDR_WIDTH-1:0]      aw_addr,
  input  logic [ID_WIDTH-1:0]        aw_id,
  input  logic [AXI_LEN_WIDTH-1:0]   aw_len,
  input  logic [AXI_SIZE_WIDTH-1:0]  aw_size,
  input  logic [AXI_BURST_WIDTH-1:0] aw_burst,
  input  logic [2:0]                 aw_prot,
  input  logic                       aw_lock,
  input  logic [3:0]                 aw_cache,
  input  logic [3:0]                 aw_qos,
  input  logic [USER_WIDTH-1:0]      aw_user,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic [DATA_WIDTH/8-1:0]    w_strb,
  input  logic                       w_last,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [AXI_RESP_WIDTH-1:0]  b_resp,
  output logic [ID_WIDTH-1:0]        b_id,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_WIDTH-1:0]      ar_addr,
  input  logic [ID_WIDTH-1:0]        ar_id,
  input  logic [AXI_LEN_WIDTH-1:0]   ar_len,
  input  logic [AXI_SIZE_WIDTH-1:0]  ar_size,
  input  logic [AXI_BURST_WIDTH-1:0] ar_burst,
  input  logic [2:0]                 ar_prot,
  input  logic                       ar_lock,
  input  logic [3:0]                 ar_cache,
  input  logic [3:0]                 ar_qos,
  input  logic [USER_WIDTH-1:0]      ar_user,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic [AXI_RESP_WIDTH-1:0]  r_resp,
  output logic                       r_last,
  output logic [ID_WIDTH-1:0]        r_id,
  output logic [USER_WIDTH-1:0]      r_user
);

  localparam int unsigned OFFB = $clog2(DATA_WIDTH/8);
  localparam int unsigned IDXW = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIM = ADDR_WIDTH'(MEM_WORDS);

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0]      a,
    input logic [AXI_SIZE_WIDTH-1:0]  sz,
    input logic [AXI_BURST_WIDTH-1:0] bu
  );
    return (bu == AXI_BURST_FIXED) ? a : a + (ADDR_WIDTH'(1) << sz);
  endfunction

  rd_state_e r_rd_state, w_rd_next;
  wr_state_e r_wr_state, w_wr_next;

  logic [ADDR_WIDTH-1:0]      r_rd_addr, r_wr_addr;
  logic [AXI_LEN_WIDTH-1:0]   r_rd_cnt, r_wr_cnt;
  logic [AXI_SIZE_WIDTH-1:0]  r_rd_size, r_wr_size;
  logic [AXI_BURST_WIDTH-1:0] r_rd_burst, r_wr_burst;
  logic [ID_WIDTH-1:0]        r_rd_id, r_wr_id;
  logic [DATA_WIDTH-1:0]      r_rd_data;
  logic [AXI_RESP_WIDTH-1:0]  r_rd_resp, r_wr_err;
  logic                       r_rd_last;

  logic                       w_ar_hs, w_r_hs, w_rd_load, w_rd_ok;
  logic [ADDR_WIDTH-1:0]      w_rd_raddr, w_rd_off;
  logic [AXI_RESP_WIDTH-1:0]  w_rd_base, w_rd_beat_resp;
  logic [DATA_WIDTH-1:0]      w_rdata;
  logic                       w_aw_hs, w_w_hs, w_wr_ok, w_wr_last_beat;
  logic [ADDR_WIDTH-1:0]      w_wr_off;
  logic [AXI_RESP_WIDTH-1:0]  w_wr_beat_resp;
  logic                       w_unused;

  assign w_unused = ^{aw_prot, aw_lock, aw_cache, aw_qos, aw_user,
                      ar_prot, ar_lock, ar_cache, ar_qos, ar_user};

  axi_mem_array #(
    .WORDS (MEM_WORDS),
    .DW    (DATA_WIDTH),
    .IDXW  (IDXW)
  ) u_array (
    .i_clk   (clock),
    .i_we    (w_w_hs && w_wr_ok),
    .i_widx  (w_wr_off[OFFB +: IDXW]),
    .i_wdata (w_data),
    .i_wstrb (w_strb),
    .i_ridx  (w_rd_off[OFFB +: IDXW]),
    .o_rdata (w_rdata)
  );

  // ---------------- read engine ----------------
  assign w_ar_hs   = ar_valid && ar_ready;
  assign w_r_hs    = r_valid && r_ready;
  assign w_rd_load = w_ar_hs || (w_r_hs && !r_rd_last);

  // Beats are registered one cycle ahead so a stalled beat cannot change under a
  // concurrent write. The response is sticky: once a beat decodes out of range, the
  // rest of the burst returns DECERR with zero data.
  always_comb begin
    w_rd_raddr     = (r_rd_state == R_IDLE) ? ar_addr
                                            : next_addr(r_rd_addr, r_rd_size, r_rd_burst);
    w_rd_off       = w_rd_raddr - BASE_ADDR;
    w_rd_ok        = (w_rd_raddr >= BASE_ADDR) && ((w_rd_off >> OFFB) < MEM_LIM);
    w_rd_base      = (r_rd_state == R_IDLE)
                   ? ((ar_burst == AXI_BURST_WRAP) ? AXI_RESP_SLVERR : AXI_RESP_OKAY)
                   : r_rd_resp;
    w_rd_beat_resp = worst_resp(w_rd_base, w_rd_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_rd_state <= R_IDLE;
    else          r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (ar_valid) w_rd_next = R_DATA;
      R_DATA:  if (r_ready && r_rd_last) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (r_rd_state == R_IDLE);
    r_valid  = (r_rd_state == R_DATA);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_id    <= '0;
      r_rd_data  <= '0;
      r_rd_resp  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rd_cnt   <= ar_len;
        r_rd_size  <= ar_size;
        r_rd_burst <= ar_burst;
        r_rd_id    <= ar_id;
        r_rd_last  <= (ar_len == '0);
      end else if (w_r_hs) begin
        r_rd_cnt  <= r_rd_cnt - AXI_LEN_WIDTH'(1);
        r_rd_last <= (r_rd_cnt == AXI_LEN_WIDTH'(1));
      end
      if (w_rd_load) begin
        r_rd_addr <= w_rd_raddr;
        r_rd_resp <= w_rd_beat_resp;
        r_rd_data <= (w_rd_beat_resp == AXI_RESP_DECERR) ? '0 : w_rdata;
      end
    end
  end

  assign r_data = r_rd_data;
  assign r_resp = r_rd_resp;
  assign r_last = r_rd_last;
  assign r_id   = r_rd_id;
  assign r_user = '0;

  // ---------------- write engine ----------------
  assign w_aw_hs        = aw_valid && aw_ready;
  assign w_w_hs         = w_valid && w_ready;
  assign w_wr_last_beat = (r_wr_cnt == '0);
  assign w_wr_off       = r_wr_addr - BASE_ADDR;
  assign w_wr_ok        = (r_wr_addr >= BASE_ADDR) && ((w_wr_off >> OFFB) < MEM_LIM);
  assign w_wr_beat_resp = worst_resp(w_wr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR,
                                     (w_last != w_wr_last_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);

  always_ff @(posedge clock) begin
    if (!reset_n) r_wr_state <= W_IDLE;
    else          r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (aw_valid) w_wr_next = W_DATA;
      W_DATA:  if (w_valid && w_wr_last_beat) w_wr_next = W_RESP;
      W_RESP:  if (b_ready) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = (r_wr_state == W_IDLE);
    w_ready  = (r_wr_state == W_DATA);
    b_valid  = (r_wr_state == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_addr  <= '0;
      r_wr_cnt   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_id    <= '0;
      r_wr_err   <= '0;
    end else if (w_aw_hs) begin
      r_wr_addr  <= aw_addr;
      r_wr_cnt   <= aw_len;
      r_wr_size  <= aw_size;
      r_wr_burst <= aw_burst;
      r_wr_id    <= aw_id;
      r_wr_err   <= (aw_burst == AXI_BURST_WRAP) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end else if (w_w_hs) begin
      r_wr_addr  <= next_addr(r_wr_addr, r_wr_size, r_wr_burst);
      r_wr_cnt   <= r_wr_cnt - AXI_LEN_WIDTH'(1);
      r_wr_err   <= worst_resp(r_wr_err, w_wr_beat_resp);
    end
  end

  assign b_resp = r_wr_err;
  assign b_id   = r_wr_id;

endmodule
